// File: rtl/alu_pkg.sv
// Shared constants for the ALU: operand/shift widths and opcode encodings.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_SRL = 5'b00110;

endpackage

// File: rtl/alu_cla_adder.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups whose group generate/
// propagate terms chain the carry between groups. Signed overflow from operand signs.
module alu_cla_adder
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              overflow
);

  localparam int NGRP = DATA_W / 4;

  always_comb begin
    logic       w_c;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_gg;
    logic       w_pg;
    logic [3:0] w_g;
    logic [3:0] w_p;
    sum  = '0;
    w_c  = cin;
    w_c1 = 1'b0;
    w_c2 = 1'b0;
    w_c3 = 1'b0;
    w_gg = 1'b0;
    w_pg = 1'b0;
    w_g  = '0;
    w_p  = '0;
    for (int k = 0; k < NGRP; k++) begin
      w_g  = a[4*k +: 4] & b[4*k +: 4];
      w_p  = a[4*k +: 4] ^ b[4*k +: 4];
      w_c1 = w_g[0] | (w_p[0] & w_c);
      w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c);
      w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c);
      w_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
      w_pg = &w_p;
      sum[4*k +: 4] = w_p ^ {w_c3, w_c2, w_c1, w_c};
      w_c = w_gg | (w_pg & w_c);
    end
  end

  // b is already inverted for subtraction, so this is the "effective" sign test.
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu.sv
// Single-stage registered ALU (add/sub/and/or/shifts) with compare flags.
// Define ALU_SRL_EN to enable opcode 00110 as a logical right shift.
// No handshake: every rising edge samples inputs and updates all outputs.
module alu #(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic [4:0]        ctrl_ALUopcode,
  input  logic [4:0]        ctrl_shiftamt,
  output logic [DATA_W-1:0] data_result,
  output logic              isNotEqual,
  output logic              isLessThan,
  output logic              overflow
);

  import alu_pkg::*;

  logic [DATA_W-1:0] w_b_eff;
  logic              w_cin;
  logic [DATA_W-1:0] w_sum;
  logic              w_add_ov;
  logic [DATA_W-1:0] w_diff;
  logic              w_sub_ov;
  logic [DATA_W-1:0] w_result;
  logic              w_ov;
  logic              w_ne;
  logic              w_lt;

  logic [DATA_W-1:0] r_result;
  logic              r_ne;
  logic              r_lt;
  logic              r_ov;

  assign w_cin   = (ctrl_ALUopcode == OP_SUB);
  assign w_b_eff = w_cin ? ~data_operandB : data_operandB;

  alu_cla_adder u_adder (
    .a        (data_operandA),
    .b        (w_b_eff),
    .cin      (w_cin),
    .sum      (w_sum),
    .overflow (w_add_ov)
  );

  // Flags need A-B on every opcode, independent of what the adder is doing.
  assign w_diff   = data_operandA + ~data_operandB + 1'b1;
  assign w_sub_ov = (data_operandA[DATA_W-1] != data_operandB[DATA_W-1])
                 && (w_diff[DATA_W-1] != data_operandA[DATA_W-1]);
  assign w_ne     = (w_diff != '0);
  assign w_lt     = w_diff[DATA_W-1] ^ w_sub_ov;

  always_comb begin
    w_result = '0;
    w_ov     = 1'b0;
    case (ctrl_ALUopcode)
      OP_ADD, OP_SUB: begin
        w_result = w_sum;
        w_ov     = w_add_ov;
      end
      OP_AND: w_result = data_operandA & data_operandB;
      OP_OR:  w_result = data_operandA | data_operandB;
      OP_SLL: w_result = data_operandA << ctrl_shiftamt;
      OP_SRA: w_result = $unsigned($signed(data_operandA) >>> ctrl_shiftamt);
`ifdef ALU_SRL_EN
      OP_SRL: w_result = data_operandA >> ctrl_shiftamt;
`endif
      default: begin
        w_result = '0;
        w_ov     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_ne     <= 1'b0;
      r_lt     <= 1'b0;
      r_ov     <= 1'b0;
    end else begin
      r_result <= w_result;
      r_ne     <= w_ne;
      r_lt     <= w_lt;
      r_ov     <= w_ov;
    end
  end

  assign data_result = r_result;
  assign isNotEqual  = r_ne;
  assign isLessThan  = r_lt;
  assign overflow    = r_ov;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: driver pushes expected {result,ne,lt,ov}
// into a queue; a monitor pops and compares one cycle after each issue.
module tb_alu;

  localparam int W  = 32;
  localparam int EW = W + 3;

  logic          clock;
  logic          reset;
  logic [W-1:0]  data_operandA;
  logic [W-1:0]  data_operandB;
  logic [4:0]    ctrl_ALUopcode;
  logic [4:0]    ctrl_shiftamt;
  logic [W-1:0]  data_result;
  logic          isNotEqual;
  logic          isLessThan;
  logic          overflow;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            total;
  int            bad;
  logic          drv_valid;
  logic          mon_valid;

  alu #(.DATA_W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_ALUopcode (ctrl_ALUopcode),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .isNotEqual     (isNotEqual),
    .isLessThan     (isLessThan),
    .overflow       (overflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) mon_valid <= 1'b0;
    else       mon_valid <= drv_valid;
  end

  // driver
  task automatic issue(input string nm, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh,
                       input logic [W-1:0] res, input logic ne, input logic lt,
                       input logic ov);
    @(negedge clock);
    data_operandA  = a;
    data_operandB  = b;
    ctrl_ALUopcode = op;
    ctrl_shiftamt  = sh;
    drv_valid      = 1'b1;
    exp_q.push_back({res, ne, lt, ov});
    name_q.push_back(nm);
  endtask

  task automatic check_now(input string nm, input logic [EW-1:0] want);
    logic [EW-1:0] got;
    got = {data_result, isNotEqual, isLessThan, overflow};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (mon_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got=%h expected=none",
                 {data_result, isNotEqual, isLessThan, overflow});
      end else begin
        logic [EW-1:0] want;
        string nm;
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        check_now(nm, want);
      end
    end
  end

  initial begin
    logic [W-1:0] srl_exp;
    total = 0;
    bad = 0;
    drv_valid = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_ALUopcode = '0;
    ctrl_shiftamt = '0;
    reset = 1'b1;
`ifdef ALU_SRL_EN
    srl_exp = 32'h0800_0000;
`else
    srl_exp = 32'h0000_0000;
`endif

    #3;
    check_now("reset_initial", '0);
    data_operandA = 32'h1234_5678;
    data_operandB = 32'h0000_0001;
    @(posedge clock);
    #1 check_now("reset_held_over_edge", '0);
    #1 reset = 1'b0;

    //     name          op      A             B             sh     result        ne    lt    ov
    issue("add_ovf",    5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 1'b0, 1'b1);
    issue("sub_ovf",    5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
    issue("sub_eq",     5'd1, 32'd5,         32'd5,         5'd0,  32'h0,         1'b0, 1'b0, 1'b0);
    issue("sub_neg",    5'd1, 32'hFFFF_FFFD, 32'd2,         5'd0,  32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0);
    issue("sra_31",     5'd5, 32'h8000_0000, 32'h0,         5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
    issue("sll_31",     5'd4, 32'h0000_0001, 32'h0,         5'd31, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    issue("sll_0",      5'd4, 32'h1234_5678, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 1'b0);
    issue("sra_0",      5'd5, 32'h8000_0001, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0, 1'b0, 1'b0);
    issue("and",        5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3,  32'hF000_F000, 1'b1, 1'b1, 1'b0);
    issue("or",         5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3,  32'hFFF0_FFF0, 1'b1, 1'b1, 1'b0);
    issue("op7_zero",   5'd7, 32'd5,         32'd3,         5'd9,  32'h0,         1'b1, 1'b0, 1'b0);
    issue("op6_srl",    5'd6, 32'h8000_0000, 32'h0,         5'd4,  srl_exp,       1'b1, 1'b1, 1'b0);
    issue("add_negovf", 5'd0, 32'h8000_0000, 32'h8000_0000, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1);
    issue("add_small",  5'd0, 32'd3,         32'd4,         5'd0,  32'd7,         1'b1, 1'b1, 1'b0);
    issue("sub_maxneg1",5'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 1'b1, 1'b0, 1'b1);
    issue("sub_noovf",  5'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5'd0,  32'h8000_0000, 1'b1, 1'b1, 1'b0);
    issue("add_shamt",  5'd0, 32'd10,        32'd20,        5'd7,  32'd30,        1'b1, 1'b1, 1'b0);

    @(negedge clock);
    drv_valid = 1'b0;
    // in-flight op that reset must discard
    data_operandA  = 32'd1;
    data_operandB  = 32'd2;
    ctrl_ALUopcode = 5'd0;
    #2 reset = 1'b1;
    #1 check_now("reset_async_clear", '0);
    @(posedge clock);
    #1 check_now("reset_discard_inflight", '0);
    #1 reset = 1'b0;
    issue("first_after_reset", 5'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    drv_valid = 1'b0;
    repeat (3) @(negedge clock);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
